// File: rtl/key_event_decoder.sv
// ============================================================================
// key_event_decoder
// ----------------------------------------------------------------------------
// Turns debounced key levels into discrete press events (CLICK, DOUBLE, LONG)
// and queues them in a small show-ahead FIFO drained through valid/ready.
//
// Ports:
//   i_clk        system clock (sole clock)
//   i_rst        synchronous, active-high reset
//   i_db         debounced key levels, 1 = pressed, synchronous to i_clk
//   o_evt_valid  FIFO head holds an event
//   o_evt_code   head event code: 1 CLICK, 2 DOUBLE, 3 LONG (0 when empty)
//   o_evt_key    key index of the head event (0 when empty)
//   i_evt_ready  consumer pops the head when high together with o_evt_valid
//   o_overflow   sticky: a pending event was overwritten before it was queued
// ============================================================================
module key_event_decoder #(
    parameter int unsigned NUMBITS     = 3,
    parameter int unsigned LONG_CYCLES = 50_000_000,
    parameter int unsigned DBL_CYCLES  = 15_000_000,
    parameter int unsigned FIFO_DEPTH  = 4,
    localparam int unsigned KW = (NUMBITS > 1) ? $clog2(NUMBITS) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NUMBITS-1:0] i_db,
    output logic               o_evt_valid,
    output logic [1:0]         o_evt_code,
    output logic [KW-1:0]      o_evt_key,
    input  logic               i_evt_ready,
    output logic               o_overflow
);

    localparam int unsigned MAXC = (LONG_CYCLES > DBL_CYCLES) ? LONG_CYCLES : DBL_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC + 1);
    localparam int unsigned FAW  = $clog2(FIFO_DEPTH);
    localparam int unsigned EW   = KW + 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DOWN1 = 3'd1;
    localparam logic [2:0] ST_HELD  = 3'd2;
    localparam logic [2:0] ST_WAIT2 = 3'd3;
    localparam logic [2:0] ST_DOWN2 = 3'd4;

    localparam logic [1:0] EVT_CLICK  = 2'd1;
    localparam logic [1:0] EVT_DOUBLE = 2'd2;
    localparam logic [1:0] EVT_LONG   = 2'd3;

    localparam logic [CW-1:0] LONG_TERM = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] DBL_TERM  = CW'(DBL_CYCLES);

    // ------------------------------------------------------------------------
    // Per-key state
    // ------------------------------------------------------------------------
    logic [NUMBITS-1:0] prev_q;
    logic [2:0]         state_q [NUMBITS];
    logic [2:0]         state_d [NUMBITS];
    logic [CW-1:0]      cnt_q   [NUMBITS];
    logic [CW-1:0]      cnt_d   [NUMBITS];
    logic [NUMBITS-1:0] pend_q, pend_d;
    logic [1:0]         pcode_q [NUMBITS];
    logic [1:0]         pcode_d [NUMBITS];
    logic               overflow_q, overflow_d;

    logic [NUMBITS-1:0] rise, fall;
    logic [NUMBITS-1:0] post;
    logic [1:0]         post_code [NUMBITS];

    // ------------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------------
    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [FAW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FAW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FAW:0]   count_q, count_d;

    logic           fifo_full;
    logic           pop;
    logic           push;
    logic           grant_vld;
    logic [KW-1:0]  grant_idx;
    logic [1:0]     grant_code;
    logic [EW-1:0]  head;

    assign rise = i_db & ~prev_q;
    assign fall = ~i_db & prev_q;

    // ------------------------------------------------------------------------
    // Press-pattern FSMs
    // ------------------------------------------------------------------------
    always_comb begin
        logic [CW-1:0] cnt_inc;
        cnt_inc = '0;
        post    = '0;
        for (int unsigned k = 0; k < NUMBITS; k++) begin
            state_d[k]   = state_q[k];
            cnt_d[k]     = cnt_q[k];
            post_code[k] = '0;
            cnt_inc      = cnt_q[k] + 1'b1;
            case (state_q[k])
                ST_IDLE: begin
                    if (rise[k]) begin
                        state_d[k] = ST_DOWN1;
                        cnt_d[k]   = CW'(1);
                    end
                end
                ST_DOWN1: begin
                    if (fall[k]) begin
                        state_d[k] = ST_WAIT2;
                        cnt_d[k]   = CW'(1);
                    end else if (cnt_inc == LONG_TERM) begin
                        post[k]      = 1'b1;
                        post_code[k] = EVT_LONG;
                        state_d[k]   = ST_HELD;
                        cnt_d[k]     = '0;
                    end else begin
                        cnt_d[k] = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (fall[k]) begin
                        state_d[k] = ST_IDLE;
                    end
                end
                ST_WAIT2: begin
                    // Gap expiry beats a simultaneous rise: the late rise is
                    // swallowed and the key returns to IDLE.
                    if (cnt_inc == DBL_TERM) begin
                        post[k]      = 1'b1;
                        post_code[k] = EVT_CLICK;
                        state_d[k]   = ST_IDLE;
                        cnt_d[k]     = '0;
                    end else if (rise[k]) begin
                        state_d[k] = ST_DOWN2;
                        cnt_d[k]   = '0;
                    end else begin
                        cnt_d[k] = cnt_inc;
                    end
                end
                ST_DOWN2: begin
                    if (fall[k]) begin
                        post[k]      = 1'b1;
                        post_code[k] = EVT_DOUBLE;
                        state_d[k]   = ST_IDLE;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Arbiter: lowest-index pending key wins the single FIFO write slot
    // ------------------------------------------------------------------------
    assign fifo_full   = (count_q == (FAW+1)'(FIFO_DEPTH));
    assign o_evt_valid = (count_q != '0);
    assign pop         = o_evt_valid & i_evt_ready;

    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_code = '0;
        for (int unsigned k = 0; k < NUMBITS; k++) begin
            if (pend_q[k] && !grant_vld) begin
                grant_vld  = 1'b1;
                grant_idx  = KW'(k);
                grant_code = pcode_q[k];
            end
        end
    end

    assign push = grant_vld & (~fifo_full | pop);

    // A post on the same edge that its predecessor is granted is not an
    // overwrite: the old code leaves for the FIFO while the new one lands.
    always_comb begin
        logic granted;
        granted    = 1'b0;
        overflow_d = overflow_q;
        pend_d     = pend_q;
        for (int unsigned k = 0; k < NUMBITS; k++) begin
            pcode_d[k] = pcode_q[k];
            granted    = push && (grant_idx == KW'(k));
            if (post[k]) begin
                pend_d[k]  = 1'b1;
                pcode_d[k] = post_code[k];
                if (pend_q[k] && !granted) begin
                    overflow_d = 1'b1;
                end
            end else if (granted) begin
                pend_d[k] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO pointers
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q     <= '1;
            pend_q     <= '0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned k = 0; k < NUMBITS; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= '0;
                pcode_q[k] <= '0;
            end
        end else begin
            prev_q     <= i_db;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int unsigned k = 0; k < NUMBITS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
                pcode_q[k] <= pcode_d[k];
            end
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {grant_idx, grant_code};
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign o_evt_code = o_evt_valid ? head[1:0]    : '0;
    assign o_evt_key  = o_evt_valid ? head[EW-1:2] : '0;
    assign o_overflow = overflow_q;

endmodule

// File: doc/key_event_decoder.md
# key_event_decoder

Consumer-side companion to the per-key debouncers: takes the debounced key levels and turns each key's press pattern into discrete events (CLICK, DOUBLE, LONG). Events go into a small FIFO that the PicoRV peripheral bus drains through a valid/ready handshake. The block sits between the debounce bank and the CPU-facing GPIO/IRQ register, so firmware never times key presses itself.

## Interface
- NUMBITS, 3, number of keys; must be ≥1.
- LONG_CYCLES, 50_000_000, press length in cycles that yields LONG; must be ≥2.
- DBL_CYCLES, 15_000_000, maximum release gap in cycles for DOUBLE; must be ≥2.
- FIFO_DEPTH, 4, event FIFO entries; power of two, ≥2.
- i_clk  in  1  system clock; sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_db  in  NUMBITS  debounced key levels, 1 = pressed; already synchronous to i_clk.
- o_evt_valid  out  1  FIFO head holds an event.
- o_evt_code  out  2  head event: 1 CLICK, 2 DOUBLE, 3 LONG; 0 never emitted.
- o_evt_key  out  max(1,$clog2(NUMBITS))  key index of head event.
- i_evt_ready  in  1  consumer pops head when high with o_evt_valid.
- o_overflow  out  1  sticky; a pending event was overwritten. Cleared only by i_rst.

## Operation
- Per key: a previous-level register `prev`, a counter wide enough for max(LONG_CYCLES, DBL_CYCLES), and an FSM. Rise = i_db & ~prev. Fall = ~i_db & prev.
- FSM states and transitions:
  - IDLE: on rise, go to DOWN1 with count = 1.
  - DOWN1: on fall, go to WAIT2 with count = 1. Otherwise count increments. When count == LONG_CYCLES, post LONG and go to HELD.
  - HELD: on fall, go to IDLE. No further events.
  - WAIT2: on rise, go to DOWN2. Otherwise count increments. When count == DBL_CYCLES, post CLICK and go to IDLE.
  - DOWN2: on fall, post DOUBLE and go to IDLE. A long second press never produces LONG.
- "Post" sets the key's pending flag and pending code.
  - If the flag is already set, the new code overwrites it and o_overflow is set.
- Arbiter: each cycle, if the FIFO is not full (or is popping this cycle), it writes the lowest-index pending key into the FIFO and clears that key's flag. At most one write per cycle.
- Backpressure: while the FIFO is full and not popping, pending flags are held. Nothing is lost unless a key re-posts.
- FIFO: show-ahead; the head is presented on o_evt_code/o_evt_key. Pop when o_evt_valid & i_evt_ready.
  - Push and pop in the same cycle is legal, including when full.
  - A pop when empty is ignored.
- Counters saturate implicitly: each exits its state at the terminal value, so no wrap is possible.

## Timing
- Reset state: every FSM in IDLE, counters 0, pending clear, FIFO empty. o_evt_valid=0, o_evt_code=0, o_evt_key=0, o_overflow=0.
- `prev` resets to all ones. A key held through reset release produces no event until it is released and pressed again.
- If i_db changes before edge k, the FSM registers it at edge k.
- Event latency: a post at edge k is written to the FIFO at edge k+1, and o_evt_valid is high after edge k+1. This assumes no backpressure and no lower-index contention.
- Exact press lengths:
  - LONG is posted at the edge where the key has read 1 for LONG_CYCLES consecutive samples.
  - A release after LONG_CYCLES−1 samples yields the CLICK/DOUBLE path.
- CLICK is posted DBL_CYCLES samples after the fall, counting the fall sample as 1.
- A rise at sample DBL_CYCLES−1 of the gap gives DOUBLE. A rise at the same edge the gap reaches DBL_CYCLES is too late: CLICK is posted and the key returns to IDLE, so that rise starts no new sequence.
- Reset asserted mid-sequence: all state returns to reset values at that edge, and queued events are discarded.

## Test plan
All scenarios use NUMBITS=3, LONG_CYCLES=8, DBL_CYCLES=5, FIFO_DEPTH=4, i_evt_ready=1 unless stated.
- Key0 high 3 cycles, then low 10 → one event code=1 key=0. o_evt_valid rises 2 cycles after the CLICK post, which is the 5th low sample.
- Key1 high 3, low 2, high 3, low → code=2 key=1, 2 cycles after the second fall.
- Key2 high 20 cycles → single code=3 key=2, o_evt_valid rising 2 cycles after the 8th high sample. Release → no further event. Gap boundary: release after 7 high samples → CLICK, not LONG.
- Keys 0 and 2 post on the same edge → FIFO receives key0 first, key2 one cycle later.
- i_evt_ready=0; generate 6 CLICKs on keys 0–2 → 4 queued, o_overflow stays 0 while no key re-posts. A key re-posting while pending → o_overflow=1. Then raise ready → events drain in order.
- Key0 held across i_rst deassertion → no event. Assert i_rst mid-WAIT2 → no CLICK, o_evt_valid=0.
